instr_fetch_buffer: RTL and testbench
=====================================

# instr_fetch_buffer

Instruction fetch buffer sitting between the instruction-memory response path and the decode stage; it is the producer end of the decode stage's `InstrD` input. It queues fetched {PC, instruction} pairs in a small FIFO and presents the head entry to decode with a valid/ready handshake, so memory latency and decode stalls are decoupled. A flush input discards all queued entries on branch redirect or exception.

## Interface
- `DEPTH`, 4, number of FIFO entries; power of two, minimum 2
- `ADDR_W`, 32, PC width
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `flush`  in  1  synchronous; discards all entries at the next edge
- `inst_valid`  in  1  memory returns an instruction this cycle
- `inst_rdata`  in  32  fetched instruction word
- `inst_pc`  in  ADDR_W  PC of `inst_rdata`
- `inst_ready`  out  1  buffer can accept a push this cycle (= not full)
- `InstrD`  out  32  head instruction to decode; 32'h0 (NOP) when empty
- `PCD`  out  ADDR_W  PC of head instruction; 0 when empty
- `instr_valid`  out  1  head entry valid (= not empty)
- `decode_ready`  in  1  decode consumes the head entry this cycle
- `level`  out  clog2(DEPTH)+1  current number of queued entries

## Operation
- Storage: DEPTH entries of {PC, instruction}; write pointer, read pointer, each clog2(DEPTH)+1 bits (extra wrap bit).
- full = pointers equal except MSB; empty = pointers fully equal; `level` = wptr − rptr modulo 2^(clog2(DEPTH)+1).
- Push: `inst_valid && inst_ready && !flush` → write entry at wptr, wptr+1.
- Pop: `instr_valid && decode_ready && !flush` → rptr+1.
- `inst_ready` depends only on current full state; a pop in the same cycle does not free space for a push in that cycle.
- Push and pop in the same cycle (not full, not empty): both happen; level unchanged.
- Push into empty buffer: entry visible at head starting the next cycle (no combinational bypass).
- `inst_valid` while full: word is dropped; the upstream fetch unit must hold or re-request it (not the buffer's job).
- `decode_ready` while empty: no effect; pointers unchanged.
- Flush: at the next edge both pointers go to 0; any same-cycle push or pop is ignored. Storage contents need not be cleared.
- Head outputs: `InstrD`/`PCD` are the entry at rptr when not empty, forced to 0 when empty.
- Pointer wrap: pointers increment modulo 2^(clog2(DEPTH)+1); the low bits index storage.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert by the system): pointers 0 → `instr_valid`=0, `InstrD`=0, `PCD`=0, `level`=0, `inst_ready`=1.
- Reset asserted mid-operation: all entries lost immediately; outputs reach reset values without waiting for a clock edge.
- Push-to-head latency: 1 cycle into an empty buffer.
- Throughput: 1 push and 1 pop per cycle sustained when neither full nor empty.
- Flush latency: `instr_valid`=0 and `inst_ready`=1 in the cycle after `flush` is sampled high.
- All outputs are functions of registered state only; no input-to-output combinational path.

## Test plan
- Reset then single push {pc=0xBFC00000, instr=0x24080001} with `decode_ready`=0 → next cycle `instr_valid`=1, `InstrD`=0x24080001, `PCD`=0xBFC00000, `level`=1; held until `decode_ready`=1, then empty.
- Fill DEPTH=4 with instrs 0x11..0x14, `decode_ready`=0 → `inst_ready`=0 after 4th push; 5th push 0x15 dropped; drain yields 0x11,0x12,0x13,0x14 in order, then `InstrD`=0.
- Continuous push and pop every cycle for 20 cycles, incrementing instrs → output sequence is in order with no gaps, `level` steady at 1, pointers wrap correctly.
- Full buffer, `decode_ready`=1 and `inst_valid`=1 same cycle → pop occurs, push rejected; `level` 4→3, following cycle push accepted.
- Buffer holding 3 entries, `flush`=1 with simultaneous push and `decode_ready`=1 → next cycle `level`=0, `instr_valid`=0, `InstrD`=0, pushed word absent.
- Reset asserted asynchronously between edges with 2 entries queued → outputs go to reset values before the next rising edge; after release, new push appears normally.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
//   Queues fetched {PC, instruction} pairs between the instruction-memory
//   response path and the decode stage, and presents the head entry to
//   decode with a valid/ready handshake. A flush discards every queued entry.
//
// Parameters
//   DEPTH   number of entries (power of two, >= 2)
//   ADDR_W  PC width
// Ports
//   clock         single clock, rising edge
//   reset         asynchronous active-high clear of all pointer state
//   flush         synchronous discard of all entries at the next edge
//   inst_valid    memory returns inst_rdata / inst_pc this cycle
//   inst_rdata    fetched instruction word
//   inst_pc       PC of inst_rdata
//   inst_ready    buffer not full (push accepted)
//   InstrD        head instruction, 0 (NOP) when empty
//   PCD           head PC, 0 when empty
//   instr_valid   head entry valid (not empty)
//   decode_ready  decode consumes the head entry this cycle
//   level         number of queued entries
module instr_fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     inst_valid,
  input  logic [31:0]              inst_rdata,
  input  logic [ADDR_W-1:0]        inst_pc,
  output logic                     inst_ready,
  output logic [31:0]              InstrD,
  output logic [ADDR_W-1:0]        PCD,
  output logic                     instr_valid,
  input  logic                     decode_ready,
  output logic [$clog2(DEPTH):0]   level
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

  logic full, empty, push, pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[IW-1:0] == rptr_q[IW-1:0]) && (wptr_q[IW] != rptr_q[IW]);

  // inst_ready is taken from the current full state only, so a same-cycle
  // pop never opens a slot for a same-cycle push.
  assign push = inst_valid && !full && !flush;
  assign pop  = !empty && decode_ready && !flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: it is only observable through a valid pointer range.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem_q[wptr_q[IW-1:0]] <= inst_rdata;
      pc_mem_q[wptr_q[IW-1:0]]    <= inst_pc;
    end
  end

  assign inst_ready  = !full;
  assign instr_valid = !empty;
  assign InstrD      = empty ? '0 : instr_mem_q[rptr_q[IW-1:0]];
  assign PCD         = empty ? '0 : pc_mem_q[rptr_q[IW-1:0]];
  assign level       = wptr_q - rptr_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              inst_valid = 1'b0;
  logic [31:0]       inst_rdata = '0;
  logic [ADDR_W-1:0] inst_pc = '0;
  logic              inst_ready;
  logic [31:0]       InstrD;
  logic [ADDR_W-1:0] PCD;
  logic              instr_valid;
  logic              decode_ready = 1'b0;
  logic [$clog2(DEPTH):0] level;

  instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .inst_valid   (inst_valid),
    .inst_rdata   (inst_rdata),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready),
    .InstrD       (InstrD),
    .PCD          (PCD),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .level        (level)
  );

  always #5 clock = ~clock;

  // Reference model: an ordered list of queued {pc, instr} words.
  logic [63:0] exp_q[$];
  logic        full_at_drive = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Apply the inputs that were just sampled at the edge to the model.
  task automatic apply_edge();
    if (flush) exp_q.delete();
    else if (inst_valid && !full_at_drive) exp_q.push_back({inst_pc, inst_rdata});
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic dr, input logic fl);
    @(posedge clock);
    apply_edge();
    #1;
    inst_valid    = v;
    inst_pc       = pc;
    inst_rdata    = ins;
    decode_ready  = dr;
    flush         = fl;
    full_at_drive = (exp_q.size() >= DEPTH);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock edge.
  task automatic async_reset_check();
    @(posedge clock);
    apply_edge();
    #1;
    inst_valid = 1'b0; decode_ready = 1'b0; flush = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_level", 64'(level), 64'd0);
    chk("async_rst_valid", 64'(instr_valid), 64'd0);
    chk("async_rst_InstrD", 64'(InstrD), 64'd0);
    chk("async_rst_PCD", 64'(PCD), 64'd0);
    chk("async_rst_ready", 64'(inst_ready), 64'd1);
    exp_q.delete();
    full_at_drive = 1'b0;
    #1 reset = 1'b0;
  endtask

  // Monitor: compares the presented head against the model every cycle and
  // retires the expected word whenever decode takes it.
  initial begin
    forever begin
      @(negedge clock);
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("instr_valid", 64'(instr_valid), 64'(exp_q.size() != 0));
      chk("inst_ready", 64'(inst_ready), 64'(exp_q.size() < DEPTH));
      if (exp_q.size() == 0) begin
        chk("empty_InstrD", 64'(InstrD), 64'd0);
        chk("empty_PCD", 64'(PCD), 64'd0);
      end else if (decode_ready && !flush) begin
        chk("pop_head", {32'(PCD), InstrD}, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        chk("head", {32'(PCD), InstrD}, exp_q[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 reset = 1'b0;
    idle(2);

    // Single push, held until decode accepts it.
    step(1'b1, 32'hBFC0_0000, 32'h2408_0001, 1'b0, 1'b0);
    idle(3);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(2);

    // Fill, overfill (0x15 dropped), drain in order.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h1000 + 32'(4*i), 32'h11 + 32'(i), 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Continuous streaming: level stays 1, pointers wrap several times.
    step(1'b1, 32'h2000, 32'h100, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) step(1'b1, 32'h2000 + 32'(4*i), 32'h100 + 32'(i), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // Full with simultaneous pop and push: push rejected, next push accepted.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(4*i), 32'h200 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h3100, 32'h299, 1'b1, 1'b0);
    step(1'b1, 32'h3104, 32'h29A, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with three entries and a same-cycle push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h4000 + 32'(4*i), 32'h300 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h4100, 32'h3FF, 1'b1, 1'b1);
    idle(2);

    // Asynchronous reset with two entries queued, then normal reuse.
    for (int i = 0; i < 2; i++) step(1'b1, 32'h5000 + 32'(4*i), 32'h400 + 32'(i), 1'b0, 1'b0);
    async_reset_check();
    step(1'b1, 32'h6000, 32'h500, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
